fifo_mem_ctrl: RTL and testbench
================================

// Module: fifo_mem_ctrl
// PURPOSE
//  Single-clock FIFO controller that sequences the 8-bit dual-port RAM (Mem) as a circular buffer.
//  Turns requester push/pop into RAM write/read enables and pointers.
//  Tracks occupancy and raises full/empty/almost flags.
//  Aligns a read-valid strobe with the RAM's 1-cycle registered read data.
//  Both RAM clock ports are tied to clk.
// PARAMETERS
//  N         8   pointer width; must satisfy 2**N >= DEPTH
//  DEPTH     90  number of RAM entries (not required to be a power of 2)
//  AF_LEVEL  80  almost_full asserts when count >= AF_LEVEL
//  AE_LEVEL  10  almost_empty asserts when count <= AE_LEVEL
// PORTS
//  clk           in   1    single clock for controller and both RAM ports
//  rst_n         in   1    asynchronous, active-low reset
//  flush         in   1    synchronous clear of pointers/count
//  push          in   1    write request; data on RAM wr_data same cycle
//  pop           in   1    read request
//  clr_err       in   1    clears sticky overflow/underflow
//  mem_wr_en     out  1    to RAM wr_en
//  mem_wr_ptr    out  N    to RAM wr_ptr
//  mem_rd_en     out  1    to RAM rd_en
//  mem_rd_ptr    out  N    to RAM rd_ptr
//  rd_valid      out  1    RAM rd_data valid this cycle
//  count         out  N+1  occupancy, 0..DEPTH
//  full/empty    out  1    count==DEPTH / count==0
//  almost_full   out  1    count >= AF_LEVEL
//  almost_empty  out  1    count <= AE_LEVEL
//  overflow      out  1    sticky: push attempted while full
//  underflow     out  1    sticky: pop attempted while empty
// BEHAVIOUR
//  - Reset (rst_n=0, async): wr_ptr=rd_ptr=0, count=0, rd_valid=0, overflow=underflow=0.
//    Hence empty=1, almost_empty=1, full=0, almost_full=0, mem_*_en=0.
//  - Accepted write: wa = push & ~full & ~flush. Accepted read: ra = pop & ~empty & ~flush.
//    Both use the registered count, so a push while full is rejected even with a same-cycle pop.
//    Likewise, a pop while empty is rejected even with a same-cycle push.
//  - mem_wr_en=wa and mem_rd_en=ra are combinational.
//    mem_wr_ptr/mem_rd_ptr are the pointer registers directly.
//  - Pointer update on accept: ptr <= (ptr==DEPTH-1) ? 0 : ptr+1. Never reaches DEPTH.
//  - count: +1 on wa only, -1 on ra only, unchanged on both or neither.
//    Saturation is impossible by construction.
//  - rd_valid <= ra. Data appears on RAM rd_data exactly 1 cycle after the accepted pop.
//  - Flags are decoded combinationally from the count register; they update the cycle after the accept.
//  - flush=1: pointers and count <= 0, rd_valid <= 0. Overrides push/pop.
//    Flags are not set by a flushed cycle.
//  - overflow <= 1 on push & full & ~flush. underflow <= 1 on pop & empty & ~flush.
//    clr_err clears both; a same-cycle set wins over clr_err.
//  - Reset mid-operation: all state returns to reset values immediately.
//    Any in-flight rd_valid is dropped.
// TESTING
//  1 Reset with push=pop=0 -> count=0, empty=1, almost_empty=1, rd_valid=0,
//    mem_wr_ptr=mem_rd_ptr=0.
//  2 Push 90 values 0..89 back-to-back -> full=1 after 90th.
//    almost_full=1 once count=80, mem_wr_ptr back to 0.
//    91st push: mem_wr_en=0, overflow=1, count stays 90.
//  3 Pop 90 -> rd_valid 1 cycle after each mem_rd_en.
//    Data 0..89 in order; empty=1 at end.
//    Extra pop -> mem_rd_en=0, underflow=1.
//    clr_err -> both sticky flags 0.
//  4 Fill to 45, then push+pop every cycle for 200 cycles -> count holds 45.
//    Both pointers wrap 89->0 repeatedly; read data matches the write sequence.
//  5 Full with push+pop same cycle -> pop accepted, push rejected, overflow=1, count=89.
//    Empty with push+pop -> push accepted, underflow=1, count=1.
//  6 Flush at count=30 with pop=1 -> next cycle count=0, rd_valid=0, pointers 0.
//    Separately, rst_n low for 1 cycle mid-burst -> all reset values immediately.

Source files
------------

// File: rtl/fifo_mem_ctrl.sv
// Single-clock FIFO controller: sequences an external dual-port RAM as a circular buffer
// of DEPTH entries and reports occupancy, threshold flags and sticky error flags.
module fifo_mem_ctrl #(
  parameter int N        = 8,
  parameter int DEPTH    = 90,
  parameter int AF_LEVEL = 80,
  parameter int AE_LEVEL = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic         clr_err,
  output logic         mem_wr_en,
  output logic [N-1:0] mem_wr_ptr,
  output logic         mem_rd_en,
  output logic [N-1:0] mem_rd_ptr,
  output logic         rd_valid,
  output logic [N:0]   count,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic         overflow,
  output logic         underflow
);

  localparam logic [N-1:0] LAST_PTR = N'(DEPTH - 1);
  localparam logic [N:0]   DEPTH_C  = (N+1)'(DEPTH);
  localparam logic [N:0]   AF_C     = (N+1)'(AF_LEVEL);
  localparam logic [N:0]   AE_C     = (N+1)'(AE_LEVEL);

  logic [N-1:0] wr_ptr_reg, wr_ptr_next;
  logic [N-1:0] rd_ptr_reg, rd_ptr_next;
  logic [N:0]   count_reg, count_next;
  logic         rd_valid_reg;
  logic         overflow_reg, underflow_reg;
  logic         wa, ra;

  // Wrap explicitly at DEPTH-1 since DEPTH need not be a power of two.
  function automatic logic [N-1:0] ptr_inc(input logic [N-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full         = (count_reg == DEPTH_C);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= AF_C);
  assign almost_empty = (count_reg <= AE_C);

  // Accept decisions use the registered count, so a simultaneous pop never frees room for a push.
  assign wa = push & ~full & ~flush;
  assign ra = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (wa) wr_ptr_next = ptr_inc(wr_ptr_reg);
    if (ra) rd_ptr_next = ptr_inc(rd_ptr_reg);
    case ({wa, ra})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      rd_valid_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      rd_valid_reg <= ra;
      // A fresh error in the same cycle beats clr_err.
      if (push & full & ~flush)      overflow_reg <= 1'b1;
      else if (clr_err)              overflow_reg <= 1'b0;
      if (pop & empty & ~flush)      underflow_reg <= 1'b1;
      else if (clr_err)              underflow_reg <= 1'b0;
    end
  end

  assign mem_wr_en  = wa;
  assign mem_rd_en  = ra;
  assign mem_wr_ptr = wr_ptr_reg;
  assign mem_rd_ptr = rd_ptr_reg;
  assign rd_valid   = rd_valid_reg;
  assign count      = count_reg;
  assign overflow   = overflow_reg;
  assign underflow  = underflow_reg;

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Directed bench for fifo_mem_ctrl with a small 1-cycle registered-read RAM attached.
module tb_fifo_mem_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n, flush, push, pop, clr_err;
  logic         mem_wr_en, mem_rd_en, rd_valid;
  logic [N-1:0] mem_wr_ptr, mem_rd_ptr;
  logic [N:0]   count;
  logic         full, empty, almost_full, almost_empty, overflow, underflow;

  logic [7:0]   wr_data;
  logic [7:0]   rd_data;
  logic [7:0]   ram [0:89];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_mem_ctrl #(.N(8), .DEPTH(90), .AF_LEVEL(80), .AE_LEVEL(10)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .pop(pop), .clr_err(clr_err),
    .mem_wr_en(mem_wr_en), .mem_wr_ptr(mem_wr_ptr), .mem_rd_en(mem_rd_en),
    .mem_rd_ptr(mem_rd_ptr), .rd_valid(rd_valid), .count(count), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_wr_ptr] <= wr_data;
    if (mem_rd_en) rd_data <= ram[mem_rd_ptr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] wval;
    logic [7:0] rval;
    rst_n = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; wr_data = '0;

    // 1: reset state
    cycle(); cycle();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ptr", mem_wr_ptr, 0);
    chk("rst_rd_ptr", mem_rd_ptr, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    rst_n = 1'b1;
    cycle();
    $display("reset released: count=%0d empty=%0b", count, empty);

    // 2: fill 0..89
    for (int i = 0; i < 90; i++) begin
      push = 1'b1; wr_data = 8'(i);
      #1 chk("fill_wr_en", mem_wr_en, 1);
      chk("fill_wr_ptr", mem_wr_ptr, i);
      cycle();
      chk("fill_count", count, i + 1);
      chk("fill_afull", almost_full, (i + 1 >= 80) ? 1 : 0);
      chk("fill_aempty", almost_empty, (i + 1 <= 10) ? 1 : 0);
      $display("push %0d -> count=%0d", i, count);
    end
    chk("fill_full", full, 1);
    chk("fill_wrap_ptr", mem_wr_ptr, 0);
    wr_data = 8'hEE;
    #1 chk("ovf_wr_en", mem_wr_en, 0);
    cycle();
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 90);
    push = 1'b0;
    $display("push on full -> overflow=%0b count=%0d", overflow, count);

    // 3: drain, data in order
    for (int i = 0; i < 90; i++) begin
      pop = 1'b1;
      #1 chk("drain_rd_en", mem_rd_en, 1);
      chk("drain_rd_ptr", mem_rd_ptr, i);
      cycle();
      chk("drain_rd_valid", rd_valid, 1);
      chk("drain_data", rd_data, i);
      $display("pop %0d -> data=%0d count=%0d", i, rd_data, count);
    end
    pop = 1'b0;
    cycle();
    chk("drain_valid_off", rd_valid, 0);
    chk("drain_empty", empty, 1);
    pop = 1'b1;
    #1 chk("udf_rd_en", mem_rd_en, 0);
    cycle();
    chk("udf_flag", underflow, 1);
    chk("udf_rd_valid", rd_valid, 0);
    pop = 1'b0; clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    chk("clr_ovf", overflow, 0);
    chk("clr_udf", underflow, 0);
    $display("pop on empty then clr_err -> ovf=%0b udf=%0b", overflow, underflow);

    // 4: hold at 45 with simultaneous push/pop, pointers wrap
    wval = 8'd0; rval = 8'd0;
    for (int i = 0; i < 45; i++) begin
      push = 1'b1; wr_data = wval;
      cycle();
      wval++;
    end
    chk("steady_fill_count", count, 45);
    pop = 1'b1;
    for (int i = 0; i < 200; i++) begin
      wr_data = wval;
      cycle();
      wval++;
      chk("steady_count", count, 45);
      chk("steady_valid", rd_valid, 1);
      chk("steady_data", rd_data, rval);
      rval++;
    end
    $display("steady: count=%0d wr_ptr=%0d rd_ptr=%0d", count, mem_wr_ptr, mem_rd_ptr);
    chk("steady_wr_ptr", mem_wr_ptr, 65);
    chk("steady_rd_ptr", mem_rd_ptr, 20);

    // 5: push+pop at full, then at empty
    pop = 1'b0;
    for (int i = 0; i < 45; i++) begin
      wr_data = wval;
      cycle();
      wval++;
    end
    chk("full2_full", full, 1);
    pop = 1'b1; push = 1'b1;
    #1 chk("full_pp_wr_en", mem_wr_en, 0);
    chk("full_pp_rd_en", mem_rd_en, 1);
    cycle();
    chk("full_pp_count", count, 89);
    chk("full_pp_ovf", overflow, 1);
    push = 1'b0;
    for (int i = 0; i < 89; i++) cycle();
    chk("empty2_empty", empty, 1);
    push = 1'b1;
    #1 chk("empty_pp_wr_en", mem_wr_en, 1);
    chk("empty_pp_rd_en", mem_rd_en, 0);
    cycle();
    chk("empty_pp_count", count, 1);
    chk("empty_pp_udf", underflow, 1);
    push = 1'b0; pop = 1'b0; clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    $display("push+pop corners done: count=%0d", count);

    // 6: flush at 30 with pop asserted
    pop = 1'b1;
    cycle();
    pop = 1'b0; push = 1'b1;
    for (int i = 0; i < 30; i++) cycle();
    push = 1'b0;
    chk("pre_flush_count", count, 30);
    flush = 1'b1; pop = 1'b1;
    #1 chk("flush_rd_en", mem_rd_en, 0);
    cycle();
    flush = 1'b0; pop = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_rd_valid", rd_valid, 0);
    chk("flush_wr_ptr", mem_wr_ptr, 0);
    chk("flush_rd_ptr", mem_rd_ptr, 0);
    chk("flush_empty", empty, 1);
    chk("flush_no_udf", underflow, 0);
    $display("flush -> count=%0d ptrs=%0d/%0d", count, mem_wr_ptr, mem_rd_ptr);

    // async reset mid-burst with a read in flight
    push = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    pop = 1'b1;
    cycle();
    chk("burst_valid", rd_valid, 1);
    chk("burst_count", count, 4);
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_rd_valid", rd_valid, 0);
    chk("arst_wr_ptr", mem_wr_ptr, 0);
    chk("arst_rd_ptr", mem_rd_ptr, 0);
    chk("arst_empty", empty, 1);
    push = 1'b0; pop = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("post_rst_count", count, 0);
    $display("async reset mid-burst -> count=%0d rd_valid=%0b", count, rd_valid);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
